// File: rtl/vga_text_writer.sv
// Text-cell writer for the vga_text bus: optional full-screen clear, then prints a
// null-terminated character stream at a cursor with newline/CR/line/screen wrap.
module vga_text_writer #(
    parameter int          ADDR_WIDTH = 64,
    parameter int          DATA_WIDTH = 64,
    parameter logic [63:0] BASE_ADDR  = 64'h30002,
    parameter int          COLS       = 80,
    parameter int          ROWS       = 90,
    parameter logic [7:0]  FILL_CHAR  = 8'd32,
    localparam int         RW         = $clog2(ROWS),
    localparam int         CW         = $clog2(COLS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [RW-1:0]         start_row,
    input  logic [CW-1:0]         start_col,
    input  logic                  char_valid,
    input  logic [7:0]            char_in,
    output logic                  char_ready,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  write,
    output logic                  read,
    output logic                  busy,
    output logic                  done,
    output logic [RW-1:0]         cursor_row,
    output logic [CW-1:0]         cursor_col
);
    localparam int CELLS = COLS * ROWS;
    localparam int NW    = $clog2(CELLS);
    localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [DATA_WIDTH-1:0] FILL_D = DATA_WIDTH'(FILL_CHAR);

    typedef enum logic [1:0] {IDLE, CLEAR, STREAM, DONE} state_t;

    state_t                state, state_n;
    logic [NW-1:0]         clr_cnt, clr_cnt_n;
    logic [RW-1:0]         row_n, row_inc;
    logic [CW-1:0]         col_n;
    logic [ADDR_WIDTH-1:0] address_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  write_n;

    assign char_ready = (state == STREAM);
    assign busy       = (state == CLEAR) || (state == STREAM);
    assign done       = (state == DONE);
    assign read       = 1'b0;
    // No scrolling: stepping past the last row lands back on row 0.
    assign row_inc    = (32'(cursor_row) == ROWS - 1) ? '0 : cursor_row + 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            clr_cnt    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            address    <= '0;
            data       <= '0;
            write      <= 1'b0;
        end else begin
            state      <= state_n;
            clr_cnt    <= clr_cnt_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            address    <= address_n;
            data       <= data_n;
            write      <= write_n;
        end
    end

    always_comb begin
        state_n   = state;
        clr_cnt_n = clr_cnt;
        row_n     = cursor_row;
        col_n     = cursor_col;
        address_n = address;
        data_n    = data;
        write_n   = 1'b0;
        case (state)
            IDLE: if (start) begin
                row_n = (32'(start_row) >= ROWS) ? '0 : start_row;
                col_n = (32'(start_col) >= COLS) ? '0 : start_col;
                if (clear) begin
                    // Cell 0 is issued on entry so every CLEAR cycle carries a write.
                    state_n   = CLEAR;
                    clr_cnt_n = '0;
                    write_n   = 1'b1;
                    address_n = BASE_A;
                    data_n    = FILL_D;
                end else begin
                    state_n = STREAM;
                end
            end
            CLEAR: begin
                if (32'(clr_cnt) == CELLS - 1) begin
                    state_n = STREAM;
                end else begin
                    clr_cnt_n = clr_cnt + 1'b1;
                    write_n   = 1'b1;
                    address_n = BASE_A + ADDR_WIDTH'(clr_cnt_n);
                    data_n    = FILL_D;
                end
            end
            STREAM: if (char_valid) begin
                case (char_in)
                    8'd0:  state_n = DONE;
                    8'd10: begin
                        col_n = '0;
                        row_n = row_inc;
                    end
                    8'd13: col_n = '0;
                    default: begin
                        write_n   = 1'b1;
                        address_n = BASE_A + ADDR_WIDTH'(cursor_row) * ADDR_WIDTH'(COLS)
                                  + ADDR_WIDTH'(cursor_col);
                        data_n    = DATA_WIDTH'(char_in);
                        if (32'(cursor_col) == COLS - 1) begin
                            col_n = '0;
                            row_n = row_inc;
                        end else begin
                            col_n = cursor_col + 1'b1;
                        end
                    end
                endcase
            end
            DONE: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_vga_text_writer.sv
// Bench for vga_text_writer: stream vectors from a table, expected cell writes
// queued on drive and checked against the write strobe; clear/reset/gap sequences by hand.
module tb_vga_text_writer;
    localparam logic [63:0] BASE = 64'h30002;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, clear = 1'b0;
    logic [6:0]  start_row = '0, start_col = '0;
    logic        char_valid = 1'b0;
    logic [7:0]  char_in = '0;
    logic        char_ready, write, read, busy, done;
    logic [63:0] address, data;
    logic [6:0]  cursor_row, cursor_col;

    vga_text_writer dut (
        .clock(clock), .reset(reset), .start(start), .clear(clear),
        .start_row(start_row), .start_col(start_col),
        .char_valid(char_valid), .char_in(char_in), .char_ready(char_ready),
        .address(address), .data(data), .write(write), .read(read),
        .busy(busy), .done(done), .cursor_row(cursor_row), .cursor_col(cursor_col)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        int               r, c, er, ec, n;
        logic [5:0][7:0]  ch;
        logic [5:0][31:0] off;   // cell offset from BASE, all-ones = no write
    } vec_t;

    wr_t  exp_q[$];
    wr_t  e;
    vec_t tbl[6];
    int   n_chk = 0, n_fail = 0;
    bit   mon_off = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // '|' stands for newline (10) and '~' for carriage return (13); a 0 terminator is appended.
    function automatic vec_t mk(int r, int c, string s, int er, int ec,
                                int o0 = -1, int o1 = -1, int o2 = -1,
                                int o3 = -1, int o4 = -1, int o5 = -1);
        vec_t v;
        v.r = r; v.c = c; v.er = er; v.ec = ec;
        v.ch = '0;
        for (int k = 0; k < s.len(); k++)
            v.ch[k] = (s[k] == "|") ? 8'd10 : (s[k] == "~") ? 8'd13 : s[k];
        v.n = s.len() + 1;
        v.off[0] = 32'(o0); v.off[1] = 32'(o1); v.off[2] = 32'(o2);
        v.off[3] = 32'(o3); v.off[4] = 32'(o4); v.off[5] = 32'(o5);
        return v;
    endfunction

    always @(negedge clock) begin
        if (!mon_off && write) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", address, data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", address, e.a);
                chk("wr_data", data, e.d);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        start = 1'b1; clear = 1'b0; start_row = 7'(v.r); start_col = 7'(v.c);
        step();
        start = 1'b0;
        chk($sformatf("v%0d_busy", idx), 64'(busy), 64'd1);
        chk($sformatf("v%0d_ready", idx), 64'(char_ready), 64'd1);
        for (int k = 0; k < v.n; k++) begin
            char_valid = 1'b1;
            char_in    = v.ch[k];
            if (v.off[k] != 32'hFFFF_FFFF)
                exp_q.push_back({BASE + 64'(v.off[k]), 64'(v.ch[k])});
            step();
        end
        char_valid = 1'b0;
        chk($sformatf("v%0d_done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d_busy_done", idx), 64'(busy), 64'd0);
        chk($sformatf("v%0d_ready_done", idx), 64'(char_ready), 64'd0);
        step();
        chk($sformatf("v%0d_done_pulse", idx), 64'(done), 64'd0);
        chk($sformatf("v%0d_row", idx), 64'(cursor_row), 64'(v.er));
        chk($sformatf("v%0d_col", idx), 64'(cursor_col), 64'(v.ec));
    endtask

    initial begin
        int good;
        tbl[0] = mk(0, 0, "TIM", 0, 3, 0, 1, 2);
        tbl[1] = mk(2, 79, "AB", 3, 1, 239, 240);
        tbl[2] = mk(89, 78, "X|Y~Z", 0, 1, 7198, -1, 0, -1, 0);
        tbl[3] = mk(100, 90, "Q", 0, 1, 0);        // out-of-range start clamps to 0/0
        tbl[4] = mk(0, 79, "a", 1, 0, 79);
        tbl[5] = mk(89, 79, "b", 0, 0, 7199);      // last cell, cursor wraps screen

        repeat (2) step();
        chk("rst_addr", address, 64'd0);
        chk("rst_data", data, 64'd0);
        chk("rst_write", 64'(write), 64'd0);
        chk("rst_read", 64'(read), 64'd0);
        chk("rst_ready", 64'(char_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_cursor", 64'({cursor_row, cursor_col}), 64'd0);
        reset = 1'b0;
        mon_off = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // gapped valid with a start pulse that must be ignored
        start = 1'b1; start_row = 7'd5; start_col = 7'd0;
        step();
        start = 1'b0;
        char_valid = 1'b1; char_in = "G"; exp_q.push_back({BASE + 64'd400, 64'd71});
        step();
        char_valid = 1'b0; start = 1'b1; start_row = 7'd0;
        step();
        start = 1'b0;
        chk("gap_busy", 64'(busy), 64'd1);
        chk("gap_ready", 64'(char_ready), 64'd1);
        chk("gap_cursor", 64'({cursor_row, cursor_col}), {50'd0, 7'd5, 7'd1});
        step();
        char_valid = 1'b1; char_in = "H"; exp_q.push_back({BASE + 64'd401, 64'd72});
        step();
        char_in = 8'd0;
        step();
        char_valid = 1'b0;
        chk("gap_done", 64'(done), 64'd1);
        step();
        chk("gap_cursor_end", 64'({cursor_row, cursor_col}), {50'd0, 7'd5, 7'd2});

        // full clear pass
        mon_off = 1'b1;
        start = 1'b1; clear = 1'b1; start_row = 7'd0; start_col = 7'd0;
        step();
        start = 1'b0; clear = 1'b0;
        good = 0;
        for (int i = 0; i < 7200; i++) begin
            if (write === 1'b1 && address === BASE + 64'(i) && data === 64'd32 &&
                char_ready === 1'b0 && busy === 1'b1)
                good++;
            if (i == 7199) chk("clear_last_addr", address, 64'h31C21);
            step();
        end
        chk("clear_cells", 64'(good), 64'd7200);
        chk("clear_end_write", 64'(write), 64'd0);
        chk("clear_end_ready", 64'(char_ready), 64'd1);
        chk("clear_end_busy", 64'(busy), 64'd1);
        mon_off = 1'b0;
        char_valid = 1'b1; char_in = 8'd0;
        step();
        char_valid = 1'b0;
        chk("clear_done", 64'(done), 64'd1);
        step();

        // reset in the middle of a clear pass
        mon_off = 1'b1;
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        repeat (100) step();
        chk("mid_addr", address, BASE + 64'd100);
        chk("mid_write", 64'(write), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_write", 64'(write), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_addr", address, 64'd0);
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_idle_write", 64'(write), 64'd0);
        mon_off = 1'b0;
        run_vec(tbl[4], 10);
        repeat (2) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
